// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: radix-2 restoring divide.
// Optional DIV_EARLY_EXIT_EN: divide-by-zero/overflow finish in one cycle.
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  op_q;
  logic [31:0] dvd;
  logic [31:0] dsr;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] a_q;
  logic [4:0]  cnt;
  logic        qneg;
  logic        rneg;
  logic        bz;

  logic        sgn;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] trial;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] fix_val;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // operand conditioning and the per-bit trial subtraction
  always_comb begin
    sgn   = ~op[0];
    a_abs = (sgn && A[31]) ? (~A + 32'd1) : A;
    b_abs = (sgn && B[31]) ? (~B + 32'd1) : B;
    trial = {rem, dvd[31]} - {1'b0, dsr};
  end

  // sign fix-up; zero divisor forces the architectural results
  always_comb begin
    q_fix = (qneg && op_q == 2'd0) ? (~quo + 32'd1) : quo;
    r_fix = (rneg && op_q == 2'd2) ? (~rem + 32'd1) : rem;
    if (bz) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = a_q;
    end
    fix_val = op_q[1] ? r_fix : q_fix;
  end

`ifdef DIV_EARLY_EXIT_EN
  logic        ovf_in;
  logic        bz_in;
  logic [31:0] early_val;

  // special cases resolvable at issue time
  always_comb begin
    bz_in  = (B == 32'd0);
    ovf_in = sgn && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    if (bz_in)
      early_val = op[1] ? A : 32'hFFFF_FFFF;
    else
      early_val = op[1] ? 32'd0 : 32'h8000_0000;
  end
`endif

  // control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= 2'd0;
      dvd    <= 32'd0;
      dsr    <= 32'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      a_q    <= 32'd0;
      cnt    <= 5'd0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      bz     <= 1'b0;
      result <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            dvd   <= a_abs;
            dsr   <= b_abs;
            a_q   <= A;
            rem   <= 32'd0;
            quo   <= 32'd0;
            cnt   <= 5'd31;
            qneg  <= sgn & (A[31] ^ B[31]);
            rneg  <= sgn & A[31];
            bz    <= (B == 32'd0);
`ifdef DIV_EARLY_EXIT_EN
            if (bz_in || ovf_in) begin
              result <= early_val;
              state  <= S_DONE;
            end else begin
              state  <= S_CALC;
            end
`else
            state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (!trial[32]) begin
              rem <= trial[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= {rem[30:0], dvd[31]};
              quo <= {quo[30:0], 1'b0};
            end
            dvd <= {dvd[30:0], 1'b0};
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0)
              state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            result <= fix_val;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle integer divide/remainder controller for the RISC-V M-extension ops (DIV, DIVU, REM, REMU) that the single-cycle integer ALU does not implement. It sits beside the ALU in the execute stage. It accepts one operation per start pulse, runs a radix-2 restoring divide one quotient bit per clock, applies sign fix-up, and returns a 32-bit result with a one-cycle done strobe. The core's hazard logic holds the pipeline while busy is high.

## Interface
- No parameters; data width is fixed at 32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- op  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU. Sampled with start.
- A  input  32  dividend. Sampled with start.
- B  input  32  divisor. Sampled with start.
- flush  input  1  abort the in-flight op (branch/trap squash).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle strobe; result is valid in the same cycle.
- result  output  32  quotient or remainder. Holds its value until the next done.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 latches op and the operands.
  - Signed ops latch |A| and |B|. Unsigned ops latch raw values.
  - Signed ops also record qneg = A[31]^B[31] and rneg = A[31].
  - Iteration counter loads 31. Next state is CALC.
- CALC, each cycle:
  - Trial remainder = {rem[31:0], dividend_msb} − {1'b0, divisor}, 33 bits.
  - If the difference is non-negative, rem takes the difference and the quotient bit is 1. Otherwise rem shifts in the bit and the quotient bit is 0.
  - Quotient and dividend shift left together.
  - When the counter reaches 0, go to FIX. Exactly 32 CALC cycles.
- FIX:
  - Select the quotient (op 0/1) or the remainder (op 2/3).
  - Negate the quotient if qneg and op=DIV. Negate the remainder if rneg and op=REM.
  - Register the selected value into result. Next state is DONE.
- DONE: done=1 for one cycle, then IDLE. A start in this cycle is ignored; a new op is accepted in IDLE only.
- Arithmetic results must match the RISC-V spec:
  - Divide by zero: quotient 0xFFFFFFFF (signed and unsigned), remainder = A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- start while busy is ignored: no state change and no operand re-latch.
- flush=1 in any non-IDLE state sends the block to IDLE next cycle. done is not asserted and result is unchanged. flush in IDLE has no effect.
- flush and start together in IDLE: flush wins and the start is dropped.
- rst overrides everything, including mid-operation.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0x00000000, counter 0.
- Normal path, start sampled at edge 0:
  - busy is high from cycle 1 through cycle 34.
  - CALC runs cycles 1–32 and FIX is cycle 33.
  - done and result are valid in cycle 34.
  - IDLE in cycle 35; the earliest next start is sampled in cycle 35.
- Back-to-back issue interval is 35 cycles.
- busy is registered. There is no combinational path from start to busy; the core stalls on start|busy.
- result changes only on the edge that enters DONE.

## Configuration
- DIV_EARLY_EXIT_EN defined:
  - IDLE detects B==0 and the signed-overflow case at start.
  - It loads the spec result directly and goes IDLE→DONE. done is in cycle 1, a latency of 1.
- DIV_EARLY_EXIT_EN undefined:
  - These cases run the full CALC/FIX path, with done in cycle 34.
  - The datapath must still produce identical spec values. FIX forces quotient 0xFFFFFFFF and remainder A for B==0, and handles overflow.

## Test plan
- DIVU A=100, B=7 → done at cycle 34, result=14. REMU with the same operands → result=2.
- DIV A=−7 (0xFFFFFFF9), B=2 → result 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1).
- DIV A=5, B=0 → 0xFFFFFFFF. REM A=5, B=0 → 5. done at cycle 1 with DIV_EARLY_EXIT_EN defined, cycle 34 without.
- DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000. REM with the same operands → 0. Check both macro settings.
- Start DIVU 100/7, pulse start with A=9, B=3 at cycle 10, assert flush at cycle 20:
  - No done is asserted and result keeps its prior value.
  - busy falls at cycle 21.
  - A new start at cycle 21 completes normally with done at cycle 55.
- Assert rst in cycle 15 of an op → cycle 16 shows busy=0, done=0, result=0. An immediate new op completes correctly.
